// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: NOP encoding, fetch FSM state encoding, and
// instruction field bit positions (also consumed by the Control_Unit decode).
// No ports; combinational helpers only.
package riscv_pkg;

  // addi x0,x0,0
  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request outstanding
    S_HOLD = 2'd1,  // instruction held for consumer
    S_DROP = 2'd2   // killed request awaiting its ack
  } fetch_state_e;

  localparam int OP_LSB = 0;
  localparam int OP_MSB = 6;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int F7_LSB = 25;
  localparam int F7_MSB = 31;

  function automatic logic [6:0] get_op(input logic [31:0] ins);
    return ins[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [2:0] get_funct3(input logic [31:0] ins);
    return ins[F3_MSB:F3_LSB];
  endfunction

  function automatic logic [6:0] get_funct7(input logic [31:0] ins);
    return ins[F7_MSB:F7_LSB];
  endfunction

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset load, +4 increment, redirect load, word alignment.
// Latency: pc_o updates one cycle after inc_i/load_i; load_i has priority over inc_i.
// Backpressure: none; caller decides when to step.
// Ports: clk_i, rst_i (sync, active-high), inc_i, load_i, target_i[31:0], pc_o[31:0].
module fetch_pc_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        load_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = align_word(target_i);
    end else if (inc_i) begin
      // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 -> 0
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= align_word(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word fetches, holds the returned instruction for decode.
// Latency: instr_valid one cycle after imem_ack; at best one instruction per 2 cycles.
// Backpressure: instr held stable with no new request while instr_valid & !instr_ready.
// Ports: clk, rst (sync, active-high); imem_req/imem_addr/imem_ack/imem_rdata memory side;
//        instr/instr_pc/op/funct3/funct7/instr_valid/instr_ready decode side;
//        redirect/redirect_target from branch resolution; fetch_cnt handshake counter.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] fetch_cnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         pc_inc;
  logic [31:0]  pc;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i    (clk),
    .rst_i    (rst),
    .inc_i    (pc_inc),
    .load_i   (redirect),
    .target_i (redirect_target),
    .pc_o     (pc)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    pc_inc     = 1'b0;

    unique case (state_q)
      S_REQ: begin
        if (redirect) begin
          // Same-cycle ack is simply dropped; otherwise the in-flight
          // response still has to be absorbed before refetching.
          state_d = imem_ack ? S_REQ : S_DROP;
        end else if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc;
          valid_d    = 1'b1;
          pc_inc     = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (valid_q && instr_ready) begin
          cnt_d   = cnt_q + 32'd1;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
        if (redirect) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        // pc already holds the latest redirect target; only wait out the ack.
        if (imem_ack) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  // Gated by rst so no request leaks out while reset is held.
  assign imem_req    = (state_q == S_REQ) && !rst;
  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign fetch_cnt   = cnt_q;
  assign op          = get_op(instr_q);
  assign funct3      = get_funct3(instr_q);
  assign funct7      = get_funct7(instr_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] fetch_cnt;

  logic        use_ovr;
  logic [31:0] ovr_dat;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory data: either a forced word or a tag derived from the address.
  assign imem_rdata = use_ovr ? ovr_dat : (imem_addr ^ 32'h1300_0000);

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .op              (op),
    .funct3          (funct3),
    .funct7          (funct7),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fetch_cnt       (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b1;
    redirect = 1'b0; redirect_target = 32'h0;
    use_ovr = 1'b0; ovr_dat = 32'h0;

    // ---- reset ----
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req",   {31'b0, imem_req},    32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr,                32'h0000_0013);
    chk("rst_ipc",   instr_pc,             32'h0);
    chk("rst_cnt",   fetch_cnt,            32'd0);

    // ---- zero-latency streaming, ready=1 ----
    rst = 1'b0; imem_ack = 1'b1; #1;
    chk("c1_req",  {31'b0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr,         32'h0);
    tick(); #1;                                    // cycle 2
    chk("c2_valid", {31'b0, instr_valid}, 32'd1);
    chk("c2_instr", instr,                32'h1300_0000);
    chk("c2_ipc",   instr_pc,             32'h0);
    chk("c2_req",   {31'b0, imem_req},    32'd0);
    tick(); #1;                                    // cycle 3
    chk("c3_addr",  imem_addr,            32'h4);
    chk("c3_valid", {31'b0, instr_valid}, 32'd0);
    tick(); #1;                                    // cycle 4
    chk("c4_ipc",   instr_pc,             32'h4);
    tick(); #1;                                    // cycle 5
    chk("c5_addr",  imem_addr,            32'h8);
    tick(); #1;                                    // cycle 6
    chk("c6_valid", {31'b0, instr_valid}, 32'd1);
    chk("c6_cnt",   fetch_cnt,            32'd2);

    // ---- delayed ack (3 cycles) ----
    tick();                                        // cycle 7
    imem_ack = 1'b0; use_ovr = 1'b1; ovr_dat = 32'h0020_8033; #1;
    chk("c7_cnt", fetch_cnt, 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("dly_addr", imem_addr,         32'hC);
      chk("dly_req",  {31'b0, imem_req}, 32'd1);
      tick(); #1;
    end
    // cycle 10: ack arrives, consumer stalls from here
    imem_ack = 1'b1; instr_ready = 1'b0; #1;
    chk("c10_addr", imem_addr, 32'hC);
    tick();                                        // cycle 11
    ovr_dat = 32'hCAFE_BABE; #1;                   // stray ack in HOLD must be ignored
    chk("dly_valid",  {31'b0, instr_valid}, 32'd1);
    chk("dly_instr",  instr,                32'h0020_8033);
    chk("dly_op",     {25'b0, op},          32'h33);
    chk("dly_f3",     {29'b0, funct3},      32'd0);
    chk("dly_f7",     {25'b0, funct7},      32'd0);

    // ---- backpressure: 5 cycles with ready=0 ----
    for (int i = 0; i < 5; i++) begin
      chk("bp_instr", instr,                32'h0020_8033);
      chk("bp_ipc",   instr_pc,             32'hC);
      chk("bp_req",   {31'b0, imem_req},    32'd0);
      chk("bp_cnt",   fetch_cnt,            32'd3);
      chk("bp_valid", {31'b0, instr_valid}, 32'd1);
      tick(); #1;
    end
    instr_ready = 1'b1; imem_ack = 1'b0; use_ovr = 1'b0; #1;
    tick(); #1;                                    // cycle 17
    chk("c17_cnt",  fetch_cnt, 32'd4);
    chk("c17_addr", imem_addr, 32'h10);

    // ---- redirect with same-cycle ack: data discarded ----
    imem_ack = 1'b1; redirect = 1'b1; redirect_target = 32'h8; #1;
    tick();                                        // cycle 18
    imem_ack = 1'b0; redirect_target = 32'h0000_0103; #1;
    chk("rda_valid", {31'b0, instr_valid}, 32'd0);
    chk("rda_addr",  imem_addr,            32'h8);
    chk("rda_req",   {31'b0, imem_req},    32'd1);

    // ---- redirect while request to 8 outstanding -> S_DROP ----
    tick();                                        // cycle 19
    redirect = 1'b0; #1;
    chk("drop_valid", {31'b0, instr_valid}, 32'd0);
    tick();                                        // cycle 20: late ack with junk
    imem_ack = 1'b1; use_ovr = 1'b1; ovr_dat = 32'hDEAD_BEEF; #1;
    chk("drop_valid2", {31'b0, instr_valid}, 32'd0);
    tick();                                        // cycle 21
    imem_ack = 1'b0; #1;
    chk("drop_nv",   {31'b0, instr_valid}, 32'd0);
    chk("drop_addr", imem_addr,            32'h100);
    chk("drop_req",  {31'b0, imem_req},    32'd1);

    // ---- repeated redirects while in S_DROP: latest wins ----
    redirect = 1'b1; redirect_target = 32'h200; #1;
    tick();                                        // cycle 22
    redirect_target = 32'h304; #1;
    chk("dd_req", {31'b0, imem_req}, 32'd0);
    tick();                                        // cycle 23
    redirect = 1'b0; imem_ack = 1'b1; #1;
    tick();                                        // cycle 24
    use_ovr = 1'b0; instr_ready = 1'b0; #1;
    chk("dd_addr", imem_addr,         32'h304);
    chk("dd_req2", {31'b0, imem_req}, 32'd1);
    tick();                                        // cycle 25
    chk("dd_instr", instr,    32'h1300_0304);
    chk("dd_ipc",   instr_pc, 32'h304);

    // ---- redirect in S_HOLD with ready: handshake still counts ----
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC; instr_ready = 1'b1; #1;
    tick();                                        // cycle 26
    redirect = 1'b0; instr_ready = 1'b0; #1;
    chk("hr_cnt",   fetch_cnt,            32'd5);
    chk("hr_valid", {31'b0, instr_valid}, 32'd0);
    chk("hr_addr",  imem_addr,            32'hFFFF_FFFC);

    // ---- pc wrap ----
    tick();                                        // cycle 27
    instr_ready = 1'b1; #1;
    chk("wr_ipc",   instr_pc, 32'hFFFF_FFFC);
    chk("wr_instr", instr,    32'hECFF_FFFC);
    tick();                                        // cycle 28
    imem_ack = 1'b0; #1;
    chk("wr_addr", imem_addr, 32'h0);
    chk("wr_cnt",  fetch_cnt, 32'd6);

    // ---- reset while in S_DROP ----
    redirect = 1'b1; redirect_target = 32'h40; #1;
    tick();                                        // cycle 29 (S_DROP)
    redirect = 1'b0; rst = 1'b1; #1;
    chk("rd_req_in_rst", {31'b0, imem_req}, 32'd0);
    tick();                                        // cycle 30
    chk("rd_valid", {31'b0, instr_valid}, 32'd0);
    chk("rd_instr", instr,                32'h0000_0013);
    chk("rd_cnt",   fetch_cnt,            32'd0);
    rst = 1'b0; imem_ack = 1'b0; #1;
    chk("rd_addr", imem_addr,         32'h0);
    chk("rd_req",  {31'b0, imem_req}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
